// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V next-PC / branch-resolution slice:
// branch funct3 codes and the control FSM state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter used for the branch statistics; sticks at all-ones.
module riscv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_pc_ctrl.sv
// Next-PC / branch-resolution stage: resolves branches from the comparator
// flags, owns the PC, raises a trap on misaligned targets and counts branches.
module riscv_pc_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             PCSel,
  output logic             trap_req,
  output logic [31:0]      trap_epc,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  state_t      state;
  logic        taken;
  logic        redirect;
  logic        misaligned;
  logic [31:0] br_tgt;
  logic [31:0] jalr_tgt;
  logic [31:0] tgt;
  logic        advance;
  logic        cnt_inc;
  logic        taken_inc;

  assign BrUn = funct3[1];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = BrEq;
      F3_BNE:  taken = !BrEq;
      F3_BLT:  taken = BrLT;
      F3_BGE:  taken = !BrLT;
      F3_BLTU: taken = BrLT;
      F3_BGEU: taken = !BrLT;
      default: taken = 1'b0;
    endcase
  end

  assign br_tgt     = pc + imm;
  assign jalr_tgt   = (rs1 + imm) & ~32'h1;
  assign tgt        = jalr ? jalr_tgt : br_tgt;
  assign redirect   = jalr | jal | (branch & taken);
  assign misaligned = redirect & tgt[1];
  assign PCSel      = redirect && (state == ST_RUN);
  assign pc_plus4   = pc + 32'd4;

  // A retiring instruction is one that leaves RUN normally; a trapping one does not count.
  assign advance   = (state == ST_RUN) && !stall && !misaligned;
  assign cnt_inc   = advance && branch && !jal && !jalr;
  assign taken_inc = cnt_inc && taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VECTOR;
      state    <= ST_RUN;
      trap_req <= 1'b0;
      trap_epc <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (misaligned) begin
              trap_epc <= pc;
              trap_req <= 1'b1;
              state    <= ST_TRAP;
            end else begin
              pc <= redirect ? tgt : pc_plus4;
            end
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            pc       <= TRAP_VECTOR;
            trap_req <= 1'b0;
            state    <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  riscv_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .count (br_cnt)
  );

  riscv_sat_counter #(.CNT_W(CNT_W)) u_br_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_inc),
    .count (br_taken_cnt)
  );

endmodule

// File: tb/tb_riscv_pc_ctrl.sv
// Scoreboard bench for riscv_pc_ctrl: directed steps push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_riscv_pc_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, branch, jal, jalr;
  logic [2:0]       funct3;
  logic [31:0]      imm, rs1;
  logic             br_eq, br_lt;
  logic             br_un;
  logic [31:0]      pc, pc_plus4;
  logic             pc_sel;
  logic             trap_req;
  logic [31:0]      trap_epc;
  logic             trap_ack;
  logic [CNT_W-1:0] br_cnt, br_taken_cnt;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pc_sel;
    logic        br_un;
    logic        trap_req;
    logic [31:0] trap_epc;
    logic [31:0] br_cnt;
    logic [31:0] br_taken_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  riscv_pc_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .funct3       (funct3),
    .imm          (imm),
    .rs1          (rs1),
    .BrEq         (br_eq),
    .BrLT         (br_lt),
    .BrUn         (br_un),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .PCSel        (pc_sel),
    .trap_req     (trap_req),
    .trap_epc     (trap_epc),
    .trap_ack     (trap_ack),
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "pc",           pc,                    e.pc);
    cmp(e.name, "pc_plus4",     pc_plus4,              e.pc + 32'd4);
    cmp(e.name, "PCSel",        {31'b0, pc_sel},       {31'b0, e.pc_sel});
    cmp(e.name, "BrUn",         {31'b0, br_un},        {31'b0, e.br_un});
    cmp(e.name, "trap_req",     {31'b0, trap_req},     {31'b0, e.trap_req});
    cmp(e.name, "trap_epc",     trap_epc,              e.trap_epc);
    cmp(e.name, "br_cnt",       32'(br_cnt),           e.br_cnt);
    cmp(e.name, "br_taken_cnt", 32'(br_taken_cnt),     e.br_taken_cnt);
  endtask

  // Monitor: the DUT presents a settled output every negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic jl,
                               input logic jr, input logic [2:0] f3,
                               input logic [31:0] im, input logic [31:0] r1,
                               input logic eq, input logic lt, input logic ack);
    stall = s; branch = b; jal = jl; jalr = jr; funct3 = f3;
    imm = im; rs1 = r1; br_eq = eq; br_lt = lt; trap_ack = ack;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic expectOut(input string name, input logic [31:0] p,
                           input logic sel, input logic un, input logic tr,
                           input logic [31:0] epc, input int bc, input int btc);
    exp_t e;
    e.name = name; e.pc = p; e.pc_sel = sel; e.br_un = un;
    e.trap_req = tr; e.trap_epc = epc;
    e.br_cnt = 32'(bc); e.br_taken_cnt = 32'(btc);
    exp_q.push_back(e);
  endtask

  // Watchdog so a stuck run still reports.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog timeout got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) nextCycle();

    nextCycle(); rst_n = 1'b1; expectOut("reset", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); expectOut("seq4",  32'h4, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); expectOut("seq8",  32'h8, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); expectOut("seq12", 32'hC, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); #3 rst_n = 1'b0; expectOut("async_rst", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); rst_n = 1'b1; expectOut("rst_rel", 32'h0, 0, 0, 0, 32'h0, 0, 0);

    nextCycle(); applyStimulus(0, 0, 1, 0, 3'b000, 32'h1C, 32'h0, 0, 0, 0);
    expectOut("jal_to_20", 32'h4, 1, 0, 0, 32'h0, 0, 0);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b001, 32'hFFFF_FFF0, 32'h0, 0, 0, 0);
    expectOut("bne_taken", 32'h20, 1, 0, 0, 32'h0, 0, 0);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b111, 32'h40, 32'h0, 0, 1, 0);
    expectOut("bgeu_not", 32'h10, 0, 1, 0, 32'h0, 1, 1);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b000, 32'h8, 32'h0, 1, 0, 0);
    expectOut("beq_taken", 32'h14, 1, 0, 0, 32'h0, 2, 1);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b100, 32'h4, 32'h0, 0, 1, 0);
    expectOut("blt_taken", 32'h1C, 1, 0, 0, 32'h0, 3, 2);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b110, 32'h8, 32'h0, 0, 1, 0);
    expectOut("bltu_taken", 32'h20, 1, 1, 0, 32'h0, 3, 3);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b010, 32'h8, 32'h0, 1, 1, 0);
    expectOut("f3_010_never", 32'h28, 0, 1, 0, 32'h0, 3, 3);
    nextCycle(); applyStimulus(0, 0, 1, 1, 3'b000, 32'h0, 32'h1001, 0, 0, 0);
    expectOut("jalr_over_jal", 32'h2C, 1, 0, 0, 32'h0, 3, 3);
    nextCycle(); applyStimulus(0, 0, 0, 1, 3'b000, 32'h0, 32'h1002, 0, 0, 0);
    expectOut("jalr_misalign", 32'h1000, 1, 0, 0, 32'h0, 3, 3);

    nextCycle(); applyStimulus(0, 0, 1, 0, 3'b000, 32'h4, 32'h0, 0, 0, 0);
    expectOut("trap_wait1", 32'h1000, 0, 0, 1, 32'h1000, 3, 3);
    nextCycle(); expectOut("trap_wait2", 32'h1000, 0, 0, 1, 32'h1000, 3, 3);
    nextCycle(); expectOut("trap_wait3", 32'h1000, 0, 0, 1, 32'h1000, 3, 3);
    nextCycle(); applyStimulus(0, 0, 1, 0, 3'b000, 32'h4, 32'h0, 0, 0, 1);
    expectOut("trap_ack", 32'h1000, 0, 0, 1, 32'h1000, 3, 3);
    nextCycle(); idle();
    expectOut("trap_vec", 32'h100, 0, 0, 0, 32'h1000, 3, 3);
    nextCycle(); applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1);
    expectOut("ack_in_run", 32'h104, 0, 0, 0, 32'h1000, 3, 3);

    nextCycle(); applyStimulus(1, 0, 1, 0, 3'b000, 32'h40, 32'h0, 0, 0, 0);
    expectOut("stall1", 32'h108, 1, 0, 0, 32'h1000, 3, 3);
    nextCycle(); expectOut("stall2", 32'h108, 1, 0, 0, 32'h1000, 3, 3);
    nextCycle(); applyStimulus(0, 0, 1, 0, 3'b000, 32'h40, 32'h0, 0, 0, 0);
    expectOut("stall3", 32'h108, 1, 0, 0, 32'h1000, 3, 3);
    nextCycle(); idle();
    expectOut("unstall", 32'h148, 0, 0, 0, 32'h1000, 3, 3);

    nextCycle(); #3 rst_n = 1'b0; expectOut("rst2", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 3'b000, 32'h8, 32'h0, 1, 0, 0);
    expectOut("stall_br", 32'h0, 1, 0, 0, 32'h0, 0, 0);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b000, 32'h8, 32'h0, 1, 0, 0);
    expectOut("stall_br_held", 32'h0, 1, 0, 0, 32'h0, 0, 0);
    nextCycle(); applyStimulus(0, 1, 0, 0, 3'b001, 32'h2, 32'h0, 0, 0, 0);
    expectOut("br_misalign", 32'h8, 1, 0, 0, 32'h0, 1, 1);
    nextCycle(); applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1);
    expectOut("br_trap", 32'h8, 0, 0, 1, 32'h8, 1, 1);
    nextCycle(); applyStimulus(0, 0, 1, 0, 3'b000, 32'hFFFF_FEFC, 32'h0, 0, 0, 0);
    expectOut("trap_vec2", 32'h100, 1, 0, 0, 32'h8, 1, 1);
    nextCycle(); idle();
    expectOut("pc_top", 32'hFFFF_FFFC, 0, 0, 0, 32'h8, 1, 1);
    nextCycle(); applyStimulus(0, 0, 0, 1, 3'b000, 32'h0, 32'h2, 0, 0, 0);
    expectOut("pc_wrap", 32'h0, 1, 0, 0, 32'h8, 1, 1);
    nextCycle(); idle();
    expectOut("trap3", 32'h0, 0, 0, 1, 32'h0, 1, 1);
    nextCycle(); #3 rst_n = 1'b0; expectOut("rst_mid_trap", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); rst_n = 1'b1; expectOut("rst3_rel", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    nextCycle(); expectOut("run_after", 32'h4, 0, 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
